// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_pkg
//  Shared types and helpers for the IF-stage PC generator.
//  - addr_t / inst_t : address and instruction bus widths
//  - fetch_state_e   : fetch sequencer states (idle, request outstanding, holding)
//  - seq_pc()        : sequential successor of a PC (32-bit wrap)
// -----------------------------------------------------------------------------
package fetch_pc_gen_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,  // no request issued yet (only right after reset)
    FETCH_WAIT = 2'd1,  // request on rom_en/rom_addr, waiting for rom_ready
    FETCH_HOLD = 2'd2   // returned instruction parked while IF/ID is stalled
  } fetch_state_e;

  localparam addr_t INST_BYTES = addr_t'(4);

  // Next sequential fetch address; carry out of bit 31 is dropped.
  function automatic addr_t seq_pc(input addr_t pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
//  Instruction ROM/SRAM request/ready handshake.
//  - rom_en    : request valid (master -> slave)
//  - rom_addr  : fetch address, stable while rom_en=1 and rom_ready=0
//  - rom_ready : rom_rdata valid this cycle (only meaningful while rom_en=1)
//  - rom_rdata : fetched instruction
//  Modports: master = PC generator, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if;
  import fetch_pc_gen_pkg::*;

  logic  rom_en;
  addr_t rom_addr;
  logic  rom_ready;
  inst_t rom_rdata;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_ready,
    input  rom_rdata
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_ready,
    output rom_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
//  One-entry skid buffer for a fetched (pc, inst) pair that came back from the
//  ROM while IF/ID was stalled.
//  Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : empty the buffer (wins over i_load)
//   i_load    : capture i_pc/i_inst
//   o_valid   : buffer holds an entry
//   o_pc/o_inst : buffered pair
// -----------------------------------------------------------------------------
module fetch_hold_buf
  import fetch_pc_gen_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_clr,
  input  logic  i_load,
  input  addr_t i_pc,
  input  inst_t i_inst,
  output logic  o_valid,
  output addr_t o_pc,
  output inst_t o_inst
);

  logic  r_valid;
  addr_t r_pc;
  inst_t r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//  IF-stage PC generator and instruction-fetch sequencer. Issues fetches on
//  the ROM handshake, delivers (pc, inst, valid) to the IF/ID register and
//  applies MIPS delay-slot branching, IF/ID stall and exception flush.
//  Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : IF/ID cannot accept this cycle
//   flush, flush_pc : one-cycle redirect pulse and its target
//   branch_flag/addr: taken branch resolved in ID and its target
//   rom             : fetch_pc_gen_if.master (rom_en/addr/ready/rdata)
//   if_valid/pc/inst: instruction presented to IF/ID
//   fetch_stall_req : outstanding fetch not yet answered
// -----------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter addr_t RESET_PC = 32'hBFC0_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  addr_t          flush_pc,
  input  logic           branch_flag,
  input  addr_t          branch_addr,
  fetch_pc_gen_if.master rom,
  output logic           if_valid,
  output addr_t          if_pc,
  output inst_t          if_inst,
  output logic           fetch_stall_req
);

  fetch_state_e r_state, w_state_next;
  addr_t        r_pc, w_pc_next;          // address of the most recent issue / restart point
  logic         r_rom_en, w_rom_en_next;
  addr_t        r_rom_addr, w_rom_addr_next;
  logic         r_drop, w_drop_next;      // outstanding request belongs to a flushed path
  logic         r_redir_pend, w_redir_pend_next;
  addr_t        r_redir_addr, w_redir_addr_next;
  logic         r_if_valid, w_if_valid_next;
  addr_t        r_if_pc, w_if_pc_next;
  inst_t        r_if_inst, w_if_inst_next;

  logic         w_buf_load, w_buf_clr, w_buf_valid;
  addr_t        w_buf_pc;
  inst_t        w_buf_inst;
  addr_t        w_issue_pc;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_buf_clr),
    .i_load  (w_buf_load),
    .i_pc    (r_rom_addr),
    .i_inst  (rom.rom_rdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst)
  );

  // Target of the next issue when no flush is active. r_rom_addr is the
  // address of the instruction being delivered now (the delay slot when a
  // branch is present), so the branch target replaces its sequential successor.
  assign w_issue_pc = r_redir_pend ? r_redir_addr :
                      branch_flag  ? branch_addr  : seq_pc(r_rom_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH_IDLE;
      r_pc         <= RESET_PC;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_drop       <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_addr <= '0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_rom_en     <= w_rom_en_next;
      r_rom_addr   <= w_rom_addr_next;
      r_drop       <= w_drop_next;
      r_redir_pend <= w_redir_pend_next;
      r_redir_addr <= w_redir_addr_next;
      r_if_valid   <= w_if_valid_next;
      r_if_pc      <= w_if_pc_next;
      r_if_inst    <= w_if_inst_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_rom_en_next     = r_rom_en;
    w_rom_addr_next   = r_rom_addr;
    w_drop_next       = r_drop;
    w_redir_pend_next = r_redir_pend;
    w_redir_addr_next = r_redir_addr;
    // Without a new instruction, a stalled IF/ID keeps its contents; an
    // unstalled one has consumed it, so valid drops to avoid a duplicate.
    w_if_valid_next   = stall ? r_if_valid : 1'b0;
    w_if_pc_next      = r_if_pc;
    w_if_inst_next    = r_if_inst;
    w_buf_load        = 1'b0;
    w_buf_clr         = 1'b0;

    if (flush) begin
      // Flush beats stall and branch: kill IF/ID, buffer and pending redirect.
      w_if_valid_next   = 1'b0;
      w_buf_clr         = 1'b1;
      w_redir_pend_next = 1'b0;
      w_pc_next         = flush_pc;
      if (r_state == FETCH_WAIT && !rom.rom_ready) begin
        // Request cannot be withdrawn; discard its data when it arrives.
        w_drop_next = 1'b1;
      end else begin
        w_drop_next     = 1'b0;
        w_state_next    = FETCH_WAIT;
        w_rom_en_next   = 1'b1;
        w_rom_addr_next = flush_pc;
      end
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          w_state_next    = FETCH_WAIT;
          w_rom_en_next   = 1'b1;
          w_rom_addr_next = r_pc;
        end
        FETCH_WAIT: begin
          if (rom.rom_ready) begin
            if (r_drop) begin
              w_drop_next     = 1'b0;
              w_rom_addr_next = r_pc;
            end else if (stall) begin
              w_buf_load    = 1'b1;
              w_state_next  = FETCH_HOLD;
              w_rom_en_next = 1'b0;
            end else begin
              w_if_valid_next   = 1'b1;
              w_if_pc_next      = r_rom_addr;
              w_if_inst_next    = rom.rom_rdata;
              w_rom_addr_next   = w_issue_pc;
              w_pc_next         = w_issue_pc;
              w_redir_pend_next = 1'b0;
            end
          end else if (!stall && branch_flag && !r_drop) begin
            // Delay slot still in flight: remember the target for its successor.
            w_redir_pend_next = 1'b1;
            w_redir_addr_next = branch_addr;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            w_if_valid_next   = w_buf_valid;
            w_if_pc_next      = w_buf_pc;
            w_if_inst_next    = w_buf_inst;
            w_buf_clr         = 1'b1;
            w_state_next      = FETCH_WAIT;
            w_rom_en_next     = 1'b1;
            w_rom_addr_next   = w_issue_pc;
            w_pc_next         = w_issue_pc;
            w_redir_pend_next = 1'b0;
          end
        end
        default: begin
          w_state_next  = FETCH_IDLE;
          w_rom_en_next = 1'b0;
        end
      endcase
    end
  end

  assign rom.rom_en      = r_rom_en;
  assign rom.rom_addr    = r_rom_addr;
  assign if_valid        = r_if_valid;
  assign if_pc           = r_if_pc;
  assign if_inst         = r_if_inst;
  assign fetch_stall_req = r_rom_en & ~rom.rom_ready;

endmodule
